// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_ODD      = 2'b01,
    PAR_EVEN     = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_e;

  // 2-of-3 majority used for the mid-bit vote
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Parametrised-depth synchroniser for asynchronous pad inputs.
module uart_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[STAGES-2:0], din};
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: majority vote, false-start rejection, break
// detection and a ready/valid output register with overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVS_FACTOR  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_ovs,
  input  logic                 rx_pin,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned OS_W = $clog2(OVS_FACTOR);
  localparam int unsigned BI_W = $clog2(DATA_BITS);
  localparam int unsigned MID  = OVS_FACTOR / 2;

  localparam logic [OS_W-1:0] OS_MID_M1 = OS_W'(MID - 1);
  localparam logic [OS_W-1:0] OS_MID    = OS_W'(MID);
  localparam logic [OS_W-1:0] OS_MID_P1 = OS_W'(MID + 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVS_FACTOR - 1);
  localparam logic [BI_W-1:0] BI_LAST   = BI_W'(DATA_BITS - 1);

  if (OVS_FACTOR < 8 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_chk_ovs
    $fatal(1, "uart_rx_param: OVS_FACTOR must be a power of 2 and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $fatal(1, "uart_rx_param: DATA_BITS must be 5..9");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "uart_rx_param: SYNC_STAGES must be >= 2");
  end

  logic line;

  uart_sync #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (rx_pin),
    .dout (line)
  );

  rx_state_e              state_q, state_d;
  logic [OS_W-1:0]        os_q, os_d;
  logic [BI_W-1:0]        bi_q, bi_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]             samp_q, samp_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop1_q, stop1_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   two_stop_q, two_stop_d;

  logic vote_c, mid_p1_c, last_c, done_c;
  logic stop1_c, stop2_c, brk_c, frame_err_c, par_err_c;
  parity_mode_e pm_c;

  // Frame status as it will stand at the completion tick
  always_comb begin
    vote_c      = maj3(samp_q[0], samp_q[1], line);
    mid_p1_c    = (os_q == OS_MID_P1);
    last_c      = (os_q == OS_LAST);
    pm_c        = parity_mode_e'(parity_mode);
    stop1_c     = (state_q == ST_STOP1) ? vote_c : stop1_q;
    stop2_c     = (state_q == ST_STOP2) ? vote_c : 1'b1;
    brk_c       = (shift_q == '0) && (!par_en_q || !par_bit_q) && !stop1_c;
    frame_err_c = !stop1_c || (two_stop_q && !stop2_c) || brk_c;
    par_err_c   = par_en_q && ((^shift_q) ^ par_bit_q ^ par_odd_q);
  end

  // Next-state and datapath logic, advancing only on oversample ticks
  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    bi_d       = bi_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_bit_d  = par_bit_q;
    stop1_d    = stop1_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    done_c     = 1'b0;

    if (tick_ovs) begin
      os_d = os_q + OS_W'(1);
      if (os_q == OS_MID_M1) samp_d[0] = line;
      if (os_q == OS_MID)    samp_d[1] = line;

      case (state_q)
        ST_IDLE: begin
          os_d = '0;
          if (!line) begin
            state_d    = ST_START;
            bi_d       = '0;
            par_en_d   = (pm_c == PAR_ODD) || (pm_c == PAR_EVEN);
            par_odd_d  = (pm_c == PAR_ODD);
            two_stop_d = two_stop;
          end
        end
        ST_START: begin
          if (mid_p1_c && vote_c) state_d = ST_IDLE;
          else if (last_c)        state_d = ST_DATA;
        end
        ST_DATA: begin
          if (mid_p1_c) shift_d[bi_q] = vote_c;
          if (last_c) begin
            if (bi_q == BI_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP1;
            else                 bi_d    = bi_q + BI_W'(1);
          end
        end
        ST_PARITY: begin
          if (mid_p1_c) par_bit_d = vote_c;
          if (last_c)   state_d   = ST_STOP1;
        end
        ST_STOP1: begin
          if (mid_p1_c) begin
            stop1_d = vote_c;
            if (!two_stop_q) begin
              done_c  = 1'b1;
              state_d = frame_err_c ? ST_WAIT_HIGH : ST_IDLE;
            end
          end
          if (last_c && two_stop_q) state_d = ST_STOP2;
        end
        ST_STOP2: begin
          if (mid_p1_c) begin
            done_c  = 1'b1;
            state_d = frame_err_c ? ST_WAIT_HIGH : ST_IDLE;
          end
        end
        ST_WAIT_HIGH: begin
          os_d = '0;
          if (line) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      os_q       <= '0;
      bi_q       <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_bit_q  <= 1'b0;
      stop1_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_q       <= os_d;
      bi_q       <= bi_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_bit_q  <= par_bit_d;
      stop1_q    <= stop1_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
    end
  end

  // Output register: a completion while a word is still pending is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      if (done_c && (!rx_valid || rx_ready)) begin
        rx_data    <= shift_q;
        parity_err <= par_err_c;
        frame_err  <= frame_err_c;
        break_det  <= brk_c;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_valid && rx_ready)     overrun_err <= 1'b0;
      else if (done_c && rx_valid)  overrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit and 7-bit instances, tick every clk.
module tb_uart_rx_param;

  logic       clk;
  logic       reset;
  logic       tick_ovs;

  logic       pin8, ts8, ready8;
  logic [1:0] pm8;
  logic [7:0] data8;
  logic       valid8, perr8, ferr8, brk8, ovr8, busy8;

  logic       pin7, ts7, ready7;
  logic [1:0] pm7;
  logic [6:0] data7;
  logic       valid7, perr7, ferr7, brk7, ovr7, busy7;

  int checks = 0;
  int errors = 0;

  int         acc8 = 0, vld8 = 0, acc7 = 0;
  logic [7:0] cap_d8;
  logic       cap_p8, cap_f8, cap_b8;
  logic [6:0] cap_d7;
  logic       cap_p7, cap_f7, cap_b7;
  int         base_acc, base_vld;

  uart_rx_param #(.DATA_BITS(8), .OVS_FACTOR(16), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .tick_ovs(tick_ovs), .rx_pin(pin8),
    .parity_mode(pm8), .two_stop(ts8), .rx_data(data8), .rx_valid(valid8),
    .rx_ready(ready8), .parity_err(perr8), .frame_err(ferr8),
    .break_det(brk8), .overrun_err(ovr8), .busy(busy8)
  );

  uart_rx_param #(.DATA_BITS(7), .OVS_FACTOR(16), .SYNC_STAGES(2)) dut7 (
    .clk(clk), .reset(reset), .tick_ovs(tick_ovs), .rx_pin(pin7),
    .parity_mode(pm7), .two_stop(ts7), .rx_data(data7), .rx_valid(valid7),
    .rx_ready(ready7), .parity_err(perr7), .frame_err(ferr7),
    .break_det(brk7), .overrun_err(ovr7), .busy(busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every accepted word away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (valid8) vld8++;
      if (valid8 && ready8) begin
        acc8++; cap_d8 = data8; cap_p8 = perr8; cap_f8 = ferr8; cap_b8 = brk8;
      end
      if (valid7 && ready7) begin
        acc7++; cap_d7 = data7; cap_p7 = perr7; cap_f7 = ferr7; cap_b7 = brk7;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame, 16 clks per bit; cut>0 aborts after that many clks
  task automatic send_frame(input int which, input logic [8:0] data, input int nd,
                            input logic has_par, input logic par_bit, input int nstop,
                            input int cut, input int glitch);
    logic [15:0] fv;
    int len;
    logic v;
    fv = '1;
    fv[0] = 1'b0;
    for (int i = 0; i < nd; i++) fv[1+i] = data[i];
    len = 1 + nd;
    if (has_par) begin
      fv[len] = par_bit;
      len++;
    end
    len = len + nstop;
    for (int i = 0; i < len * 16; i++) begin
      if (cut > 0 && i >= cut) break;
      v = fv[i/16] ^ (i == glitch);
      if (which == 0) pin8 = v; else pin7 = v;
      step(1);
    end
  endtask

  initial begin
    reset = 1'b1; tick_ovs = 1'b1;
    pin8 = 1'b1; pm8 = 2'b00; ts8 = 1'b0; ready8 = 1'b1;
    pin7 = 1'b1; pm7 = 2'b10; ts7 = 1'b1; ready7 = 1'b1;
    step(4);
    check("reset_valid", 32'(valid8), 32'd0);
    check("reset_data",  32'(data8),  32'd0);
    check("reset_busy",  32'(busy8),  32'd0);
    check("reset_ovr",   32'(ovr8),   32'd0);
    reset = 1'b0;
    step(10);

    // 8N1 0x55
    base_acc = acc8; base_vld = vld8;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 0, -1);
    step(20);
    check("t1_accepts",   32'(acc8 - base_acc), 32'd1);
    check("t1_valid_cyc", 32'(vld8 - base_vld), 32'd1);
    check("t1_data",      32'(cap_d8), 32'h55);
    check("t1_perr",      32'(cap_p8), 32'd0);
    check("t1_ferr",      32'(cap_f8), 32'd0);
    check("t1_brk",       32'(cap_b8), 32'd0);

    // 7E2 0x3A with wrong parity bit
    base_acc = acc7;
    send_frame(1, 9'h03A, 7, 1'b1, 1'b1, 2, 0, -1);
    step(20);
    check("t2_accepts", 32'(acc7 - base_acc), 32'd1);
    check("t2_data",    32'(cap_d7), 32'h3A);
    check("t2_perr",    32'(cap_p7), 32'd1);
    check("t2_ferr",    32'(cap_f7), 32'd0);

    // False start: low for 6 ticks only
    base_acc = acc8;
    pin8 = 1'b0;
    step(4);
    check("t3_busy_on", 32'(busy8), 32'd1);
    step(2);
    pin8 = 1'b1;
    step(10);
    check("t3_busy_off", 32'(busy8), 32'd0);
    step(20);
    check("t3_no_word", 32'(acc8 - base_acc), 32'd0);

    // Single-tick glitch in the middle of data bit 0 of 0x00
    base_acc = acc8;
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 0, 24);
    step(20);
    check("t3_glitch_cnt",  32'(acc8 - base_acc), 32'd1);
    check("t3_glitch_data", 32'(cap_d8), 32'h00);
    check("t3_glitch_ferr", 32'(cap_f8), 32'd0);

    // Break: line low for 3 frame times
    base_acc = acc8;
    pin8 = 1'b0;
    step(480);
    check("t4_brk_cnt",  32'(acc8 - base_acc), 32'd1);
    check("t4_brk_data", 32'(cap_d8), 32'h00);
    check("t4_brk_ferr", 32'(cap_f8), 32'd1);
    check("t4_brk_det",  32'(cap_b8), 32'd1);
    check("t4_brk_busy", 32'(busy8), 32'd1);
    pin8 = 1'b1;
    step(30);
    check("t4_after_cnt",  32'(acc8 - base_acc), 32'd1);
    check("t4_after_busy", 32'(busy8), 32'd0);
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 0, -1);
    step(20);
    check("t4_next_cnt",  32'(acc8 - base_acc), 32'd2);
    check("t4_next_data", 32'(cap_d8), 32'h81);

    // Back-to-back 0xA5, 0x5A with consumer stalled
    ready8 = 1'b0;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 0, -1);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 0, -1);
    step(20);
    check("t5_valid", 32'(valid8), 32'd1);
    check("t5_data",  32'(data8),  32'hA5);
    check("t5_ovr",   32'(ovr8),   32'd1);
    ready8 = 1'b1;
    step(1);
    check("t5_valid_clr", 32'(valid8), 32'd0);
    check("t5_ovr_clr",   32'(ovr8),   32'd0);
    step(10);

    // Reset during data bit 4
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 16 + 64 + 8, -1);
    reset = 1'b1;
    step(1);
    check("t6_rst_valid", 32'(valid8), 32'd0);
    check("t6_rst_data",  32'(data8),  32'd0);
    check("t6_rst_perr",  32'(perr8),  32'd0);
    check("t6_rst_ferr",  32'(ferr8),  32'd0);
    check("t6_rst_brk",   32'(brk8),   32'd0);
    check("t6_rst_ovr",   32'(ovr8),   32'd0);
    check("t6_rst_busy",  32'(busy8),  32'd0);
    reset = 1'b0;
    pin8 = 1'b1;
    step(20);
    base_acc = acc8;
    send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 0, -1);
    step(20);
    check("t6_c3_cnt",  32'(acc8 - base_acc), 32'd1);
    check("t6_c3_data", 32'(cap_d8), 32'hC3);
    check("t6_c3_ferr", 32'(cap_f8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampled UART receiver with configurable frame format, 3-sample majority voting, false-start rejection, break detection and a ready/valid output with overrun reporting. It sits between the pad-side serial input and the byte-stream consumer: `tick_ovs` comes from the shared baud generator and the received words go to the RX FIFO or CPU register bank.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `OVS_FACTOR`, 16: oversampling ticks per bit; power of 2, ≥8. Any other value triggers `$fatal` at elaboration.
- `SYNC_STAGES`, 2: synchroniser depth on `rx_pin`, ≥2.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `tick_ovs` in 1: one-`clk` enable pulse at OVS_FACTOR × baud.
- `rx_pin` in 1: asynchronous serial line, idle high.
- `parity_mode` in 2: 00 none, 01 odd, 10 even, 11 none.
- `two_stop` in 1: 1 selects two stop bits.
- `rx_data` out DATA_BITS: received word, LSB first on the wire.
- `rx_valid` out 1: `rx_data` and the status flags are valid.
- `rx_ready` in 1: consumer accepts.
- `parity_err` out 1: parity check failed; qualified by `rx_valid`.
- `frame_err` out 1: a stop bit sampled 0; qualified by `rx_valid`.
- `break_det` out 1: line held low for the whole frame; qualified by `rx_valid`.
- `overrun_err` out 1: one or more frames dropped; sticky.
- `busy` out 1: FSM is not in IDLE.

## Operation
- `rx_pin` passes through SYNC_STAGES flops every `clk`. These flops reset to 1. The FSM and counters advance only on `clk` edges where `tick_ovs`=1.
- `os_count` is $clog2(OVS_FACTOR) bits and wraps OVS_FACTOR-1→0. `MID` = OVS_FACTOR/2.
- Majority vote: take samples at `os_count` = MID-1, MID and MID+1. The bit value is latched at MID+1 as the 2-of-3 majority.
- States:
  - IDLE: synced line 0 on a tick → START, `os_count`=0.
  - START: at MID+1, vote 1 → IDLE (false start, nothing output); vote 0 → continue. At OVS_FACTOR-1 → DATA.
  - DATA: the voted bit goes into `rx_shift[bit_index]`. At OVS_FACTOR-1, `bit_index`++. After bit DATA_BITS-1 → PARITY if `parity_mode` ∈ {01,10}, otherwise STOP1.
  - PARITY: latch the voted bit. Error when XOR of data and parity is 0 (odd mode) or 1 (even mode).
  - STOP1: at MID+1, latch the voted bit. If `two_stop`=1 → STOP2 at OVS_FACTOR-1. Otherwise the frame completes at MID+1.
  - STOP2: same as STOP1; the frame completes at MID+1. A 0 in either stop bit sets `frame_err`.
  - Frame complete: go to IDLE, or to WAIT_HIGH if `frame_err`. Completing at mid-stop allows back-to-back frames.
  - WAIT_HIGH: stay until the synced line is 1 on a tick, then → IDLE. This prevents re-triggering during a break.
- `break_det` = all data bits 0, parity (if present) 0, and first stop 0. `frame_err` is also 1 when `break_det` is 1.
- `parity_mode` and `two_stop` are sampled on leaving IDLE and held for the frame.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, all error flags 0, `busy`=0. State → IDLE, counters 0.
- A reset mid-frame aborts the frame with no output.
- Output register load: on the completion tick's `clk` edge, `rx_data` and the flags are loaded and `rx_valid`=1 from the next cycle.
- Handshake: `rx_valid`&`rx_ready` in cycle N → `rx_valid`=0 in N+1, independent of `tick_ovs`. `rx_valid` never drops without acceptance.
- Completion while `rx_valid`=1 and `rx_ready`=0: the new frame is dropped, `rx_data` is unchanged and `overrun_err`=1. `overrun_err` clears on the next accept.
- Completion and acceptance in the same cycle: the new frame loads, `rx_valid` stays 1 and there is no overrun.
- Worst-case latency from the start edge to `rx_valid`: SYNC_STAGES clk + (1+DATA_BITS+P+S-1)·OVS_FACTOR + MID+2 ticks + 1 clk, where P is 1 with parity and S is the number of stop bits.

## Structure
- Package `uart_pkg`: `parity_mode_e` and `rx_state_e` enums. The majority function `maj3` also lives here.
- Sub-module `uart_sync`: parametrised-depth synchroniser with a reset value parameter. It is shared with future CTS/RTS inputs.
- The FSM, counters, shift register and output register live in `uart_rx_param`.

## Test plan
- 8N1, OVS16, byte 0x55, `rx_ready`=1 → `rx_data`=0x55, `rx_valid` for 1 cycle, all error flags 0.
- 7E2, byte 0x3A with wrong parity bit 1 → `rx_data`=0x3A, `parity_err`=1, `frame_err`=0.
- Start pulse low for 6 ticks only → no `rx_valid`, `busy` returns to 0 after the MID+1 tick. Single-tick glitch at MID of data bit 0x00 → `rx_data`=0x00.
- Line held low for 3 frame times, 8N1 → one word 0x00 with `frame_err`=1 and `break_det`=1. No further words until the line goes high and a new start bit arrives.
- Frames 0xA5 then 0x5A back-to-back with `rx_ready`=0 → `rx_data`=0xA5, `overrun_err`=1. Then `rx_ready`=1 → `rx_valid`=0 and `overrun_err`=0 next cycle.
- `reset` asserted during data bit 4 → next cycle all outputs 0. A following clean frame 0xC3 is received correctly.
